// File: rtl/frag_mem_responder.sv
// Memory-side load responder: captures one mem_read request, returns the stored
// word with a one-cycle mem_ack a fixed number of cycles later.
module frag_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic [31:0]       mem_address,
   output logic              mem_ack,
   output logic [31:0]       mem_Message,
   output logic              busy,
   output logic              addr_err,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data
);

   typedef enum logic [1:0] {IDLE, BUSY, ACK, DRAIN} state_e;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                err_q, err_d;
   logic                ack_q, ack_d;
   logic [31:0]         msg_q, msg_d;
   logic                busy_q, busy_d;
   logic                aerr_q, aerr_d;

   logic [31:0]         store [0:(1<<ADDR_W)-1];

   // NOTE: every always_comb target gets a default before the case; a path
   // that leaves one unassigned would infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      err_d   = err_q;
      ack_d   = 1'b0;
      msg_d   = msg_q;
      busy_d  = busy_q;
      aerr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read) begin
               idx_d   = mem_address[ADDR_W+1:2];
               err_d   = (mem_address[1:0] != 2'b00) || (mem_address[31:ADDR_W+2] != '0);
               cnt_d   = LAT_M1;
               state_d = BUSY;
               busy_d  = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = ACK;
               ack_d   = 1'b1;
               msg_d   = err_q ? 32'h0 : store[idx_q];
               aerr_d  = err_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACK: begin
            // A still-asserted mem_read belongs to the request just served.
            if (mem_read) begin
               state_d = DRAIN;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         DRAIN: begin
            if (!mem_read) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, including the store read above.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         ack_q   <= 1'b0;
         msg_q   <= 32'h0;
         busy_q  <= 1'b0;
         aerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
         msg_q   <= msg_d;
         busy_q  <= busy_d;
         aerr_q  <= aerr_d;
      end
   end

   // NOTE: the store has no reset so it maps onto plain RAM; preload writes
   // are accepted in every state, even during reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         store[wr_addr] <= wr_data;
      end
   end

   assign mem_ack     = ack_q;
   assign mem_Message = msg_q;
   assign busy        = busy_q;
   assign addr_err    = aerr_q;

endmodule

// File: doc/frag_mem_responder.md
Name: frag_mem_responder

Overview:
- Memory-side responder for the fragment controller's load path: samples the controller's mem_read/mem_address request and returns mem_Message with a single-cycle mem_ack after a fixed latency.
- Holds a word-addressed data store that a host/bench preload port can write.
- Sits between the controller and the fragment data memory.
- Serves one outstanding request at a time using a four-phase-style handshake.

Parameters:
- ADDR_W, 8, word-index width; store depth is 2**ADDR_W words.
- LATENCY, 2, cycles from request capture to mem_ack; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  load request from the controller, level-held until mem_ack is seen.
- mem_address  input  32  byte address; word index is mem_address[ADDR_W+1:2].
- mem_ack  output  1  one-cycle pulse; mem_Message is valid in the same cycle.
- mem_Message  output  32  read data; holds its value until the next ack.
- busy  output  1  high from request capture until the handshake returns to IDLE.
- addr_err  output  1  high with mem_ack when the request was out of range or misaligned.
- wr_en  input  1  preload write strobe.
- wr_addr  input  ADDR_W  preload word index.
- wr_data  input  32  preload data.

Behaviour:
- Reset values: mem_ack=0, mem_Message=0, busy=0, addr_err=0, FSM=IDLE, latency counter=0. Store contents are not reset.
- IDLE, on a clock edge with mem_read=1:
  - latch the word index; latch err = (mem_address[1:0]!=0) | (mem_address[31:ADDR_W+2]!=0);
  - load counter=LATENCY-1; go to BUSY; busy=1.
- BUSY: counter decrements each edge. At the edge where counter==0:
  - go to ACK, register mem_ack=1;
  - mem_Message = err ? 32'h0 : store[latched index], reading the pre-edge array value;
  - addr_err = err.
- Latency: capture edge T gives mem_ack high in the cycle following edge T+LATENCY. With LATENCY=1, ack is high in the cycle after T+1.
- ACK (one cycle): on the next edge mem_ack=0 and addr_err=0; mem_Message holds.
  - If mem_read=1 on that edge, go to DRAIN; else go to IDLE.
  - busy=0 on the transition into IDLE.
- DRAIN: wait until mem_read is sampled 0, then go to IDLE. A new request needs mem_read to be low for at least one sampled edge. This prevents a held mem_read from being served twice.
- mem_address and mem_read changes while in BUSY/ACK/DRAIN are ignored; only the captured index is used.
- Preload writes:
  - wr_en=1 writes store[wr_addr]=wr_data at the edge, in any state.
  - A write to the latched index at the same edge as the BUSY->ACK read returns the old data. A write on any earlier edge is visible.
- Reset asserted in any state: next edge forces reset values. An in-flight request is dropped with no mem_ack. A controller still holding mem_read=1 after reset is treated as a new request in IDLE.
- Counter width is 4 bits; LATENCY outside 1..15 is a configuration error and its behaviour is undefined.

Test Plan:
- Preload store[5]=32'hDEADBEEF; LATENCY=2; mem_read=1, mem_address=32'h14 captured at edge T, dropped after ack → mem_ack high exactly in the cycle after edge T+2, mem_Message=32'hDEADBEEF, addr_err=0, busy=0 two edges after the ack edge.
- mem_read held high continuously for 10 cycles at address 32'h14 → exactly one mem_ack pulse. After mem_read falls for one cycle and rises again, a second ack arrives LATENCY cycles after recapture.
- mem_address=32'h15 (misaligned), then 32'h400 (index 256, out of range for ADDR_W=8) → each returns mem_ack with addr_err=1 and mem_Message=0.
- Read store[3]=32'h11111111; wr_en writes 32'h22222222 to index 3 on the BUSY->ACK edge → mem_Message=32'h11111111. A repeat read → 32'h22222222.
- rst=1 for one edge while in BUSY → no mem_ack, all outputs 0. With mem_read still 1 after rst falls, a fresh request is captured and acked after LATENCY cycles.
- LATENCY=1 instance: back-to-back requests with a one-cycle low gap each → acks one cycle after capture, data matches preloaded values 32'hA5A5A5A5 and 32'h5A5A5A5A.
